// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl : branch direction predictor and resolution controller (RV32I)
//
// IF side : predicts conditional-branch direction from a table of 2-bit
//           saturating counters (BHT) indexed by pc[IDX_W+1:2]. The prediction
//           and the next fetch PC are combinational and have zero latency.
// EX side : drives BrUn_o to the branch comparator and decodes funct3 together
//           with BrEq_i/BrLt_i into a taken/not-taken outcome. A mispredict
//           raises redirect_o with the corrected PC in the same cycle. The BHT
//           entry is trained on the clock edge that ends the resolve cycle.
//
// Ports
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   if_valid_i, if_is_br_i            IF stage valid / conditional-branch predecode
//   if_pc_i, if_target_i              IF address / branch target
//   pred_taken_o, pred_pc_o           IF prediction / next fetch PC
//   ex_valid_i, ex_is_br_i            EX stage valid / conditional branch
//   ex_funct3_i, ex_pc_i, ex_target_i EX branch funct3 / address / target
//   ex_pred_taken_i                   prediction carried down from IF
//   stall_i                           EX stage frozen this cycle
//   BrUn_o, BrEq_i, BrLt_i            comparator interface
//   redirect_o, redirect_pc_o         mispredict flush request / corrected PC
//   illegal_br_o                      funct3 010/011 on a resolving branch
//   br_cnt_o, mispred_cnt_o           saturating performance counters
// -----------------------------------------------------------------------------
module branch_ctrl #(
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             if_valid_i,
   input  logic             if_is_br_i,
   input  logic [31:0]      if_pc_i,
   input  logic [31:0]      if_target_i,
   output logic             pred_taken_o,
   output logic [31:0]      pred_pc_o,
   input  logic             ex_valid_i,
   input  logic             ex_is_br_i,
   input  logic [2:0]       ex_funct3_i,
   input  logic [31:0]      ex_pc_i,
   input  logic [31:0]      ex_target_i,
   input  logic             ex_pred_taken_i,
   input  logic             stall_i,
   output logic             BrUn_o,
   input  logic             BrEq_i,
   input  logic             BrLt_i,
   output logic             redirect_o,
   output logic [31:0]      redirect_pc_o,
   output logic             illegal_br_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int N_ENT = 2 ** IDX_W;

   // 2-bit saturating counter step: increment when taken, decrement otherwise
   function automatic logic [1:0] bht_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end else begin
         res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
      end
      return res;
   endfunction

   // performance counter increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      return (&cnt) ? cnt : cnt + CNT_W'(1);
   endfunction

   logic [1:0]       bht_q [N_ENT];
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0] if_idx_s, ex_idx_s;
   logic             taken_s, legal_s, br_active_s, resolve_s;
   logic [1:0]       ex_cnt_upd_s, if_cnt_s;

   assign if_idx_s = if_pc_i[IDX_W+1:2];
   assign ex_idx_s = ex_pc_i[IDX_W+1:2];

   // funct3 decode into branch outcome and legality
   always_comb begin
      taken_s = 1'b0;
      legal_s = 1'b1;
      case (ex_funct3_i)
         3'b000:         taken_s = BrEq_i;
         3'b001:         taken_s = ~BrEq_i;
         3'b100, 3'b110: taken_s = BrLt_i;
         3'b101, 3'b111: taken_s = ~BrLt_i;
         default:        legal_s = 1'b0;
      endcase
   end

   // resolution, redirect and IF prediction (with same-index bypass)
   always_comb begin
      BrUn_o        = ex_funct3_i[1];
      // rst_i gating keeps every combinational output at its reset value
      // while reset is held, including the cycle it is asserted mid-stream
      br_active_s   = ~rst_i & ex_valid_i & ex_is_br_i & ~stall_i;
      resolve_s     = br_active_s & legal_s;
      illegal_br_o  = br_active_s & ~legal_s;
      redirect_o    = resolve_s & (taken_s != ex_pred_taken_i);
      redirect_pc_o = taken_s ? ex_target_i : ex_pc_i + 32'd4;

      ex_cnt_upd_s  = bht_step(bht_q[ex_idx_s], taken_s);
      // IF sees the value the EX update is about to write on the same entry
      if (resolve_s && (if_idx_s == ex_idx_s)) begin
         if_cnt_s = ex_cnt_upd_s;
      end else begin
         if_cnt_s = bht_q[if_idx_s];
      end
      pred_taken_o  = if_valid_i & if_is_br_i & if_cnt_s[1];
      pred_pc_o     = pred_taken_o ? if_target_i : if_pc_i + 32'd4;
   end

   // next-state of the performance counters
   always_comb begin
      br_cnt_d      = resolve_s  ? sat_inc(br_cnt_q)      : br_cnt_q;
      mispred_cnt_d = redirect_o ? sat_inc(mispred_cnt_q) : mispred_cnt_q;
   end

   // BHT storage: all entries weakly not-taken on reset, trained on resolve
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < N_ENT; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else if (resolve_s) begin
         bht_q[ex_idx_s] <= ex_cnt_upd_s;
      end else begin
         bht_q[ex_idx_s] <= bht_q[ex_idx_s];
      end
   end

   // performance counter registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign br_cnt_o      = br_cnt_q;
   assign mispred_cnt_o = mispred_cnt_q;

endmodule
